pps_register_file: RTL
======================

Name: pps_register_file

Overview:
- Architectural register file: the consuming end of the writeback interface.
- Accepts the write-back triple (destination, write enable, write data) from the WB stage.
- Serves two registered read ports to the decode (ID) stage, with same-cycle write-to-read bypass and stall-hold.
- A combinational debug read port gives direct array visibility.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH (32).
- RWE_SIZE, 1, width of the write-enable field (matches WB RegWrite width); a write occurs when any bit is set.
- RESET_VALUE, 0, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ID_stall  input  1  decode stall; when high, read addresses are held.
- ID_rs_addr  input  ADDR_WIDTH  read port A address (rs).
- ID_rt_addr  input  ADDR_WIDTH  read port B address (rt).
- WB_inst_rd_in  input  ADDR_WIDTH  write destination register.
- WB_RegWrite_in  input  RWE_SIZE  write enable.
- WB_RF_Wdata_in  input  DATA_WIDTH  write data.
- RF_rs_data_out  output  DATA_WIDTH  registered read data, port A.
- RF_rt_data_out  output  DATA_WIDTH  registered read data, port B.
- dbg_addr  input  ADDR_WIDTH  debug read address.
- dbg_data  output  DATA_WIDTH  combinational debug read data, no bypass.

Behaviour:
- Reset (rst=1 at rising edge):
  - All registers load RESET_VALUE; register 0 always reads 0 regardless.
  - Held addresses go to 0.
  - RF_rs_data_out and RF_rt_data_out go to 0.
  - A write presented in the same cycle is discarded.
- Write:
  - At the rising edge, if |WB_RegWrite_in and WB_inst_rd_in != 0 and rst=0, then regs[WB_inst_rd_in] <= WB_RF_Wdata_in.
  - Writes to register 0 are ignored; register 0 is hardwired zero.
- Effective read address per port: eff = ID_stall ? held_addr : ID_xx_addr. Each edge (rst=0): held_addr <= eff.
- Read data per port, each edge (rst=0):
  - eff == 0 -> 0.
  - Else, if a write occurs this cycle with WB_inst_rd_in == eff -> WB_RF_Wdata_in (bypass).
  - Else -> regs[eff] (pre-edge contents).
- Latency: address presented in cycle N -> data valid on outputs in cycle N+1 and held until the next edge.
- Stall:
  - Outputs keep tracking the held address every cycle.
  - A write to a held register during a stall updates the output on the following cycle, so no stale operand survives a stall.
- Both ports may address the same register; both receive identical data, including the bypass value.
- Port A and port B bypass independently; one write may bypass to both ports.
- dbg_data = (dbg_addr == 0) ? 0 : regs[dbg_addr]. Shows pre-write contents in the write cycle and the new value after the edge.
- Reset asserted mid-stall: held addresses clear to 0 and outputs read 0 on the next cycle, regardless of ID_stall.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then read:
  - Write 0xDEADBEEF to r5, assert rst one cycle, read r5 on port A -> RF_rs_data_out = 0x00000000; dbg_addr=5 -> dbg_data = 0.
- Basic write/read latency:
  - Write r3=0x12345678 in cycle 1; set ID_rs_addr=3 in cycle 2 -> RF_rs_data_out = 0x12345678 in cycle 3, not before.
- Same-cycle bypass on both ports:
  - r7 holds 0x1; in one cycle write r7=0xCAFEF00D with ID_rs_addr=ID_rt_addr=7.
  - Next cycle -> both outputs = 0xCAFEF00D; dbg_data(7) was 0x1 during the write cycle.
- Register 0:
  - Write r0=0xFFFFFFFF, read r0 on both ports and debug -> all 0.
  - Bypass is not applied even in the write cycle.
- Stall hold with intervening write:
  - Port B reads r9=0xAAAA0000; raise ID_stall and change ID_rt_addr to 4.
  - Write r9=0x5555 during the stall -> RF_rt_data_out = 0xAAAA0000, then 0x5555 the cycle after the write.
  - Drop ID_stall -> r4 contents appear the next cycle.
- Reset mid-stall plus write collision:
  - With ID_stall=1 on r9, assert rst together with write r9=0x77 -> next cycle outputs = 0, regs[9] = 0 (write discarded).

Source files
------------

// File: rtl/pps_register_file.sv
// rtl/pps_register_file.sv - architectural register file with bypassed, stall-holding read ports
// Two registered read ports with write-to-read bypass, plus a combinational debug port.
module pps_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RWE_SIZE = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_stall,
  input  logic [ADDR_WIDTH-1:0] ID_rs_addr,
  input  logic [ADDR_WIDTH-1:0] ID_rt_addr,
  input  logic [ADDR_WIDTH-1:0] WB_inst_rd_in,
  input  logic [RWE_SIZE-1:0]   WB_RegWrite_in,
  input  logic [DATA_WIDTH-1:0] WB_RF_Wdata_in,
  output logic [DATA_WIDTH-1:0] RF_rs_data_out,
  output logic [DATA_WIDTH-1:0] RF_rt_data_out,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [ADDR_WIDTH-1:0] held_rs, held_rt;
  logic [ADDR_WIDTH-1:0] eff_rs, eff_rt;
  logic [DATA_WIDTH-1:0] next_rs, next_rt;
  logic                  wr_en;

  assign wr_en = (|WB_RegWrite_in) && (WB_inst_rd_in != '0);

  always_comb begin
    eff_rs = ID_stall ? held_rs : ID_rs_addr;
    eff_rt = ID_stall ? held_rt : ID_rt_addr;

    // Register 0 wins over bypass; wr_en already excludes rd == 0.
    if (eff_rs == '0)
      next_rs = '0;
    else if (wr_en && (WB_inst_rd_in == eff_rs))
      next_rs = WB_RF_Wdata_in;
    else
      next_rs = regs[eff_rs];

    if (eff_rt == '0)
      next_rt = '0;
    else if (wr_en && (WB_inst_rd_in == eff_rt))
      next_rt = WB_RF_Wdata_in;
    else
      next_rt = regs[eff_rt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= RESET_VALUE;
      held_rs        <= '0;
      held_rt        <= '0;
      RF_rs_data_out <= '0;
      RF_rt_data_out <= '0;
    end else begin
      if (wr_en)
        regs[WB_inst_rd_in] <= WB_RF_Wdata_in;
      held_rs        <= eff_rs;
      held_rt        <= eff_rt;
      RF_rs_data_out <= next_rs;
      RF_rt_data_out <= next_rt;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
